divider: RTL and testbench
==========================

Name: divider

Overview:
- Multi-cycle radix-2 restoring integer divider for the RV32M/DIV family (DIV, DIVU, REM, REMU).
- Sits in the execute stage beside the ALU. The execute stage stalls on busy_o and captures result_o when done_o pulses.
- Uses the shared D_IDLE/D_INIT/D_CALC/D_SIGN state encoding and the one-hot iType_e instruction encoding.

Parameters:
XLEN, 32, operand and result width in bits; only 32 is supported.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
start_i  input  1  request a division; sampled only in D_IDLE
kill_i  input  1  flush from the pipeline; aborts any operation in progress
op_i  input  iType_e  operation; only DIV, DIVU, REM and REMU are legal
rs1_data_i  input  XLEN  dividend
rs2_data_i  input  XLEN  divisor
busy_o  output  1  high in every state except D_IDLE
done_o  output  1  one-cycle pulse: result_o is valid
result_o  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state = D_IDLE; busy_o = 0; done_o = 0; result_o = 0; all internal registers = 0.
- Reset or kill_i in any state: go to D_IDLE on the next edge, suppress done_o, leave result_o unchanged. Reset has priority over kill_i, and kill_i has priority over start_i.
- D_IDLE, start_i = 1 with a legal op_i:
  - Latch op_i, the operands, and signed = op in {DIV, REM}.
  - Go to D_INIT.
  - start_i with an illegal op_i is ignored.
- D_INIT (1 cycle):
  - Form the absolute values of the operands when signed.
  - Record neg_q = sign(rs1) XOR sign(rs2) and neg_r = sign(rs1).
  - Clear the remainder register, load the quotient register with |dividend|, reset the iteration counter to 0.
  - Detect the special cases below; if one applies, load the special result and go straight to D_SIGN with the correction disabled.
  - Otherwise go to D_CALC.
- Special cases:
  - Divisor 0: quotient = all ones, remainder = dividend (unsigned or signed alike).
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- D_CALC (exactly 32 cycles):
  - Each cycle, shift {rem, quo} left by one.
  - Compute trial = rem − divisor in 33 bits. If it is non-negative, rem = trial and quo[0] = 1.
  - The counter runs 0..31 and has no wrap; when it reaches 31 the next state is D_SIGN.
- D_SIGN (1 cycle):
  - Negate the quotient when neg_q and signed; negate the remainder when neg_r and signed.
  - Register into result_o either the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - Go to D_IDLE and assert done_o for the following cycle.
- Latency, with start accepted at edge N:
  - Normal path: D_INIT during N+1, D_CALC during N+2..N+33, D_SIGN during N+34; done_o = 1 and result_o valid during N+35.
  - Special-case path: done_o during N+3.
- start_i in the same cycle as done_o: accepted (the state is D_IDLE), so back-to-back operations are allowed.
- start_i while busy_o = 1: ignored; operand changes after acceptance have no effect.
- result_o holds its value until the next D_SIGN.

Decomposition:
- Shared package: div_states_e and iType_e already exist; no new typedefs are needed.
- Add a package constant DIV_ITERATIONS = XLEN.
- Optional sub-module div_sign_fix: combinational conditional two's-complement negation, instantiated twice in D_SIGN.
- Everything else is a single module with the state register, counter, and {rem, quo} datapath.

Test Plan:
1. DIVU 0xFFFFFFFF / 1 → result_o 0xFFFFFFFF; done_o exactly 35 cycles after start; busy_o high for 34 cycles.
2. DIV 20 / −3 → 0xFFFFFFFA (−6). REM 20 / −3 → 2. REM −20 / 3 → 0xFFFFFFFE (−2).
3. DIVU 7 / 0 → 0xFFFFFFFF; REMU 7 / 0 → 7; DIV −5 / 0 → 0xFFFFFFFF; all with done_o 3 cycles after start.
4. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0; done_o after 3 cycles.
5. Start DIV 100 / 7, then assert kill_i at cycle 10 → no done_o, busy_o low next cycle. Then start DIVU 100 / 7 → 14 after 35 cycles. Repeat with reset instead of kill_i: same outcome, and result_o reads 0 after reset.
6. Back-to-back: assert start_i (REMU 100 / 7) during the done_o cycle of the previous op → second done_o 35 cycles later with result 2. A start_i pulse with new operands while busy is ignored.

Source files
------------

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared types and constants for the multi-cycle integer
//               divider: divider state encoding, one-hot instruction
//               encoding, iteration count and op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    // Datapath width; the divider supports 32-bit operation only.
    localparam int DIV_XLEN       = 32;
    // One restoring step per quotient bit.
    localparam int DIV_ITERATIONS = DIV_XLEN;
    localparam int DIV_CNT_W      = $clog2(DIV_ITERATIONS);

    // Divider control states.
    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_INIT = 2'd1,
        D_CALC = 2'd2,
        D_SIGN = 2'd3
    } div_states_e;

    // One-hot execute-stage instruction class.
    typedef enum logic [7:0] {
        I_ADD  = 8'b0000_0001,
        I_SUB  = 8'b0000_0010,
        I_MUL  = 8'b0000_0100,
        I_MULH = 8'b0000_1000,
        I_DIV  = 8'b0001_0000,
        I_DIVU = 8'b0010_0000,
        I_REM  = 8'b0100_0000,
        I_REMU = 8'b1000_0000
    } iType_e;

    // True for the four operations the divider accepts.
    function automatic logic is_div_op(input iType_e op);
        return (op == I_DIV) || (op == I_DIVU) || (op == I_REM) || (op == I_REMU);
    endfunction

    // True for the signed variants.
    function automatic logic is_signed_op(input iType_e op);
        return (op == I_DIV) || (op == I_REM);
    endfunction

    // True when the remainder, rather than the quotient, is returned.
    function automatic logic is_rem_op(input iType_e op);
        return (op == I_REM) || (op == I_REMU);
    endfunction

endpackage : divider_pkg
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_fix
// Description : Combinational conditional two's-complement negation.
//               o_value = i_negate ? -i_value : i_value
// Ports       : i_value  [WIDTH] magnitude in
//               i_negate [1]     negate when high
//               o_value  [WIDTH] corrected value
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_negate ? (~i_value + {{(WIDTH-1){1'b0}}, 1'b1}) : i_value;

endmodule : div_sign_fix
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
//               IDLE -> INIT (abs values, special cases) -> CALC (32 steps)
//               -> SIGN (sign correction, result register) -> IDLE + done.
// Ports       : clk, reset      clock / synchronous active-high reset
//               start_i         request; sampled only in D_IDLE
//               kill_i          pipeline flush; aborts any operation
//               op_i            iType_e operation (DIV/DIVU/REM/REMU legal)
//               rs1_data_i      dividend
//               rs2_data_i      divisor
//               busy_o          high whenever not in D_IDLE
//               done_o          one-cycle pulse, result_o valid
//               result_o        quotient or remainder, held until next op
// Revision    : 1.0 - initial release
// ============================================================================
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            kill_i,
    input  iType_e          op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [DIV_CNT_W-1:0] c_LAST_ITER = DIV_CNT_W'(DIV_ITERATIONS - 1);
    localparam logic [DIV_CNT_W-1:0] c_CNT_ONE   = DIV_CNT_W'(1);
    localparam logic [XLEN-1:0]      c_INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    div_states_e           r_state;
    div_states_e           w_next_state;

    logic [XLEN-1:0]       r_a;         // latched dividend (raw)
    logic [XLEN-1:0]       r_b;         // latched divisor (raw)
    logic                  r_signed;
    logic                  r_is_rem;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_quo;
    logic [XLEN-1:0]       r_div;       // |divisor|
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_fix_en;    // cleared for special-case results
    logic [DIV_CNT_W-1:0]  r_cnt;
    logic                  r_done;
    logic [XLEN-1:0]       r_result;

    logic                  w_start_ok;
    logic [XLEN-1:0]       w_a_abs;
    logic [XLEN-1:0]       w_b_abs;
    logic                  w_div_zero;
    logic                  w_overflow;
    logic [XLEN:0]         w_shift;
    logic [XLEN:0]         w_trial;
    logic                  w_ge;
    logic [XLEN-1:0]       w_quo_fixed;
    logic [XLEN-1:0]       w_rem_fixed;

    assign w_start_ok = start_i && is_div_op(op_i);

    assign w_a_abs = (r_signed && r_a[XLEN-1]) ? (~r_a + {{(XLEN-1){1'b0}}, 1'b1}) : r_a;
    assign w_b_abs = (r_signed && r_b[XLEN-1]) ? (~r_b + {{(XLEN-1){1'b0}}, 1'b1}) : r_b;

    assign w_div_zero = (r_b == '0);
    assign w_overflow = r_signed && (r_a == c_INT_MIN) && (&r_b);

    // Shifted partial remainder is XLEN+1 bits wide. When its top bit is set
    // it necessarily exceeds the divisor, so the subtraction always succeeds
    // and the low XLEN bits of the trial are still exact.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_div};
    assign w_ge    = w_shift[XLEN] || !w_trial[XLEN];

    div_sign_fix #(.WIDTH(XLEN)) u_quo_fix (
        .i_value  (r_quo),
        .i_negate (r_fix_en && r_signed && r_neg_q),
        .o_value  (w_quo_fixed)
    );

    div_sign_fix #(.WIDTH(XLEN)) u_rem_fix (
        .i_value  (r_rem),
        .i_negate (r_fix_en && r_signed && r_neg_r),
        .o_value  (w_rem_fixed)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; kill overrides everything, including a new start.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (kill_i) begin
            w_next_state = D_IDLE;
        end else begin
            case (r_state)
                D_IDLE:  if (w_start_ok) w_next_state = D_INIT;
                D_INIT:  w_next_state = (w_div_zero || w_overflow) ? D_SIGN : D_CALC;
                D_CALC:  if (r_cnt == c_LAST_ITER) w_next_state = D_SIGN;
                D_SIGN:  w_next_state = D_IDLE;
                default: w_next_state = D_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_is_rem <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fix_en <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (!kill_i) begin
                case (r_state)
                    D_IDLE: begin
                        if (w_start_ok) begin
                            r_a      <= rs1_data_i;
                            r_b      <= rs2_data_i;
                            r_signed <= is_signed_op(op_i);
                            r_is_rem <= is_rem_op(op_i);
                        end
                    end
                    D_INIT: begin
                        r_div   <= w_b_abs;
                        r_neg_q <= r_a[XLEN-1] ^ r_b[XLEN-1];
                        r_neg_r <= r_a[XLEN-1];
                        r_cnt   <= '0;
                        if (w_div_zero) begin
                            // Remainder is the raw dividend, so no sign fix.
                            r_quo    <= '1;
                            r_rem    <= r_a;
                            r_fix_en <= 1'b0;
                        end else if (w_overflow) begin
                            r_quo    <= c_INT_MIN;
                            r_rem    <= '0;
                            r_fix_en <= 1'b0;
                        end else begin
                            r_quo    <= w_a_abs;
                            r_rem    <= '0;
                            r_fix_en <= 1'b1;
                        end
                    end
                    D_CALC: begin
                        r_rem <= w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                        if (r_cnt != c_LAST_ITER) begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    D_SIGN: begin
                        r_result <= r_is_rem ? w_rem_fixed : w_quo_fixed;
                        r_done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o   = (r_state != D_IDLE);
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule : divider
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider
// Description : Directed self-checking bench for the divider: latency,
//               busy duration, signed/unsigned results, divide-by-zero,
//               signed overflow, kill/reset abort, back-to-back starts and
//               ignored starts while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;
    import divider_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic        kill_i;
    iType_e      op_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_pass   = 0;

    divider #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .kill_i     (kill_i),
        .op_i       (op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one operation from an idle (or done) cycle and follow it to
    // done_o. Returns positioned in the done cycle, so a following call
    // starts back-to-back. With poke set, a second start with other
    // operands is pulsed while busy and must be ignored.
    task automatic run_op(input string tag, input iType_e op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat,
                          input bit poke);
        int lat;
        int busy_cnt;
        op_i       = op;
        rs1_data_i = a;
        rs2_data_i = b;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        lat        = 1;
        busy_cnt   = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (poke && lat == 5) begin
                op_i       = I_DIVU;
                rs1_data_i = 32'd9;
                rs2_data_i = 32'd3;
                start_i    = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start_i = 1'b0;
        check({tag, " latency"},     lat,      exp_lat);
        check({tag, " result"},      result_o, exp);
        check({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, " busy_at_done"}, {31'd0, busy_o}, 32'd0);
    endtask

    // Start DIV 100/7 and abort it at cycle 10 with kill or reset.
    task automatic abort_op(input bit use_reset, input logic [31:0] exp_result);
        bit seen;
        op_i       = I_DIV;
        rs1_data_i = 32'd100;
        rs2_data_i = 32'd7;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        if (use_reset) reset = 1'b1;
        else           kill_i = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        kill_i = 1'b0;
        check(use_reset ? "reset busy" : "kill busy", {31'd0, busy_o}, 32'd0);
        check(use_reset ? "reset done" : "kill done", {31'd0, done_o}, 32'd0);
        check(use_reset ? "reset result" : "kill result", result_o, exp_result);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        check(use_reset ? "reset no_done" : "kill no_done", {31'd0, seen}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start_i    = 1'b0;
        kill_i     = 1'b0;
        op_i       = I_ADD;
        rs1_data_i = '0;
        rs2_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset busy",   {31'd0, busy_o}, 32'd0);
        check("reset done",   {31'd0, done_o}, 32'd0);
        check("reset result", result_o,        32'd0);

        // A start with a non-divide op is ignored.
        op_i       = I_ADD;
        rs1_data_i = 32'd5;
        rs2_data_i = 32'd1;
        start_i    = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("illegal op busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;

        // Full-latency unsigned path.
        run_op("divu max/1",  I_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, 1'b0);

        // Signed results (back-to-back from here on).
        run_op("div 20/-3",   I_DIV,  32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 35, 1'b0);
        run_op("rem 20/-3",   I_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         35, 1'b0);
        run_op("rem -20/3",   I_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 35, 1'b0);

        // Signed overflow special case.
        run_op("div ovf",     I_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3, 1'b0);
        run_op("rem ovf",     I_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         3, 1'b0);

        // Divide by zero.
        run_op("divu 7/0",    I_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 3, 1'b0);
        run_op("remu 7/0",    I_REMU, 32'd7,         32'd0,         32'd7,         3, 1'b0);
        run_op("rem -5/0",    I_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 3, 1'b0);
        run_op("div -5/0",    I_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 3, 1'b0);

        // Kill mid-operation: result keeps the previous value.
        abort_op(1'b0, 32'hFFFF_FFFF);
        run_op("divu 100/7 after kill",  I_DIVU, 32'd100, 32'd7, 32'd14, 35, 1'b0);

        // Reset mid-operation: result clears.
        abort_op(1'b1, 32'd0);
        run_op("divu 100/7 after reset", I_DIVU, 32'd100, 32'd7, 32'd14, 35, 1'b0);

        // Back-to-back REMU with an ignored start pulse while busy.
        run_op("remu 100/7 b2b", I_REMU, 32'd100, 32'd7, 32'd2, 35, 1'b1);

        // done_o is a single-cycle pulse.
        @(posedge clk); #1;
        check("done pulse width", {31'd0, done_o}, 32'd0);
        check("result held",      result_o,        32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_divider
`default_nettype wire
